// File: rtl/ir_fetch_ctrl.sv
// Instruction-fetch sequencer: assembles 16-bit instructions from byte memory
// into the IR and hands them to the decoder via a valid/ready handshake.
module ir_fetch_ctrl #(
   parameter int unsigned            ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [7:0]        mem_data,
   input  logic              instr_ready,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        ir_I,
   output logic [1:0]        ir_funsel,
   output logic              ir_lh,
   output logic              ir_enable,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc
);

   typedef enum logic [2:0] {
      S_CLR,
      S_IDLE,
      S_FETCH_LO,
      S_FETCH_HI,
      S_VALID
   } state_t;

   localparam logic [1:0] FS_CLR  = 2'b00;
   localparam logic [1:0] FS_LOAD = 2'b01;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_CLR;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_funsel   = FS_CLR;
      ir_lh       = 1'b0;
      ir_enable   = 1'b0;
      instr_valid = 1'b0;
      unique case (state_q)
         S_CLR: begin
            ir_enable = 1'b1;
            state_d   = S_IDLE;
         end
         S_IDLE: begin
            if (run) state_d = S_FETCH_LO;
         end
         S_FETCH_LO: begin
            ir_enable = 1'b1;
            ir_funsel = FS_LOAD;
            pc_d      = pc_q + ADDR_W'(1);
            state_d   = S_FETCH_HI;
         end
         S_FETCH_HI: begin
            ir_enable = 1'b1;
            ir_funsel = FS_LOAD;
            ir_lh     = 1'b1;
            pc_d      = pc_q + ADDR_W'(1);
            state_d   = S_VALID;
         end
         S_VALID: begin
            instr_valid = 1'b1;
            // pc_load only matters on the handshake edge
            if (instr_ready) begin
               if (pc_load) pc_d = pc_in;
               state_d = run ? S_FETCH_LO : S_IDLE;
            end
         end
         default: state_d = S_CLR;
      endcase
   end

   assign mem_addr = pc_q;
   assign pc       = pc_q;
   assign ir_I     = mem_data;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Directed bench for ir_fetch_ctrl: reset, fetch, back-pressure, jump,
// PC wrap, stop at boundary and asynchronous reset mid-fetch.
module tb_ir_fetch_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [7:0] mem_data;
   logic       instr_ready;
   logic       pc_load;
   logic [7:0] pc_in;
   logic [7:0] mem_addr;
   logic [7:0] ir_I;
   logic [1:0] ir_funsel;
   logic       ir_lh;
   logic       ir_enable;
   logic       instr_valid;
   logic [7:0] pc;

   logic [7:0] mem [256];

   int checks = 0;
   int errors = 0;

   ir_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .mem_data    (mem_data),
      .instr_ready (instr_ready),
      .pc_load     (pc_load),
      .pc_in       (pc_in),
      .mem_addr    (mem_addr),
      .ir_I        (ir_I),
      .ir_funsel   (ir_funsel),
      .ir_lh       (ir_lh),
      .ir_enable   (ir_enable),
      .instr_valid (instr_valid),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   assign mem_data = mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {enable, funsel, lh, valid}
   function automatic logic [4:0] ctl();
      return {ir_enable, ir_funsel, ir_lh, instr_valid};
   endfunction

   localparam logic [4:0] C_CLR  = 5'b1_00_0_0;
   localparam logic [4:0] C_IDLE = 5'b0_00_0_0;
   localparam logic [4:0] C_LO   = 5'b1_01_0_0;
   localparam logic [4:0] C_HI   = 5'b1_01_1_0;
   localparam logic [4:0] C_VAL  = 5'b0_00_0_1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[0]     = 8'h34;
      mem[1]     = 8'h12;
      mem[2]     = 8'hCD;
      mem[3]     = 8'hAB;
      mem[8'h40] = 8'h78;
      mem[8'h41] = 8'h56;
      mem[8'hFF] = 8'hEE;

      rst_n       = 1'b0;
      run         = 1'b0;
      instr_ready = 1'b0;
      pc_load     = 1'b0;
      pc_in       = 8'h00;
      #3;
      chk("rst_ctl", 32'(ctl()), 32'(C_CLR));
      chk("rst_pc", 32'(pc), 32'h00);

      @(negedge clk);
      rst_n       = 1'b1;
      run         = 1'b1;
      instr_ready = 1'b1;
      #1;
      chk("clr_ctl", 32'(ctl()), 32'(C_CLR));

      tick();
      chk("idle_ctl", 32'(ctl()), 32'(C_IDLE));
      tick();
      chk("lo0_ctl", 32'(ctl()), 32'(C_LO));
      chk("lo0_addr", 32'(mem_addr), 32'h00);
      chk("lo0_I", 32'(ir_I), 32'h34);
      tick();
      chk("hi0_ctl", 32'(ctl()), 32'(C_HI));
      chk("hi0_addr", 32'(mem_addr), 32'h01);
      chk("hi0_I", 32'(ir_I), 32'h12);
      tick();
      chk("val0_ctl", 32'(ctl()), 32'(C_VAL));
      chk("val0_pc", 32'(pc), 32'h02);

      // back-pressure, with a pc_load that must be ignored
      instr_ready = 1'b0;
      pc_load     = 1'b1;
      pc_in       = 8'h80;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ctl", 32'(ctl()), 32'(C_VAL));
         chk("bp_pc", 32'(pc), 32'h02);
      end
      instr_ready = 1'b1;
      pc_load     = 1'b0;
      tick();
      chk("lo1_ctl", 32'(ctl()), 32'(C_LO));
      chk("lo1_addr", 32'(mem_addr), 32'h02);
      chk("lo1_I", 32'(ir_I), 32'hCD);
      tick();
      chk("hi1_addr", 32'(mem_addr), 32'h03);
      chk("hi1_I", 32'(ir_I), 32'hAB);
      tick();
      chk("val1_ctl", 32'(ctl()), 32'(C_VAL));
      chk("val1_pc", 32'(pc), 32'h04);

      // jump to 0x40
      pc_load = 1'b1;
      pc_in   = 8'h40;
      tick();
      pc_load = 1'b0;
      chk("jmp_ctl", 32'(ctl()), 32'(C_LO));
      chk("jmp_addr", 32'(mem_addr), 32'h40);
      chk("jmp_I", 32'(ir_I), 32'h78);
      tick();
      chk("jmp_hi_addr", 32'(mem_addr), 32'h41);
      tick();
      chk("jmp_val_pc", 32'(pc), 32'h42);

      // jump to 0xFF: instruction straddles the wrap
      pc_load = 1'b1;
      pc_in   = 8'hFF;
      tick();
      pc_load = 1'b0;
      chk("wrap_lo_addr", 32'(mem_addr), 32'hFF);
      chk("wrap_lo_I", 32'(ir_I), 32'hEE);
      tick();
      chk("wrap_hi_ctl", 32'(ctl()), 32'(C_HI));
      chk("wrap_hi_addr", 32'(mem_addr), 32'h00);
      chk("wrap_hi_I", 32'(ir_I), 32'h34);
      tick();
      chk("wrap_val_ctl", 32'(ctl()), 32'(C_VAL));
      chk("wrap_val_pc", 32'(pc), 32'h01);

      // stop: drop run during FETCH_HI
      tick();
      chk("stop_lo_addr", 32'(mem_addr), 32'h01);
      tick();
      chk("stop_hi_ctl", 32'(ctl()), 32'(C_HI));
      run = 1'b0;
      tick();
      chk("stop_val_ctl", 32'(ctl()), 32'(C_VAL));
      chk("stop_val_pc", 32'(pc), 32'h03);
      tick();
      chk("stop_idle_ctl", 32'(ctl()), 32'(C_IDLE));
      chk("stop_idle_pc", 32'(pc), 32'h03);
      tick();
      chk("stop_hold_ctl", 32'(ctl()), 32'(C_IDLE));
      chk("stop_hold_pc", 32'(pc), 32'h03);

      // async reset in the middle of FETCH_HI
      run = 1'b1;
      tick();
      chk("ar_lo_addr", 32'(mem_addr), 32'h03);
      tick();
      chk("ar_hi_ctl", 32'(ctl()), 32'(C_HI));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ctl", 32'(ctl()), 32'(C_CLR));
      chk("ar_pc", 32'(pc), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ar_clr_ctl", 32'(ctl()), 32'(C_CLR));
      tick();
      chk("ar_idle_ctl", 32'(ctl()), 32'(C_IDLE));
      chk("ar_idle_pc", 32'(pc), 32'h00);
      tick();
      chk("ar_lo_ctl", 32'(ctl()), 32'(C_LO));
      chk("ar_lo0_addr", 32'(mem_addr), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_fetch_ctrl.md
Name: ir_fetch_ctrl

Overview:
- Instruction-fetch sequencer that sits directly upstream of the 16-bit instruction register (IR).
- Reads two consecutive bytes from byte-wide program memory (asynchronous read) and drives the IR's I / FunSel / LH / enable inputs to assemble a 16-bit instruction.
- Holds the program counter (PC).
- Offers each completed instruction to the downstream decoder through an instr_valid/instr_ready handshake; supports PC reload for jumps.

Parameters:
- ADDR_W, 8: width of PC and mem_addr.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  1 = fetching allowed; 0 = stop at next instruction boundary.
- mem_data  input  8  byte read from program memory at mem_addr, valid in the same cycle.
- instr_ready  input  1  decoder accepts the current IR contents.
- pc_load  input  1  load PC from pc_in, sampled only on handshake.
- pc_in  input  ADDR_W  jump target.
- mem_addr  output  ADDR_W  program memory address; always equals PC.
- ir_I  output  8  IR byte input; combinational copy of mem_data.
- ir_funsel  output  2  IR function select: 00 clear, 01 load.
- ir_lh  output  1  IR half select: 0 low, 1 high.
- ir_enable  output  1  IR enable.
- instr_valid  output  1  IR holds a complete instruction.
- pc  output  ADDR_W  current PC.

Behaviour:
- States: CLR, IDLE, FETCH_LO, FETCH_HI, VALID. Encoding is free.
- All control outputs are Moore decodes of state; there are no combinational paths from instr_ready or run to any output.
- Reset (rst_n=0, asynchronous, any state, including mid-fetch):
  - state=CLR, PC=RESET_PC, instr_valid=0.
  - ir_enable=1, ir_funsel=00 while in CLR.
- CLR (one cycle):
  - Outputs: ir_enable=1, ir_funsel=00, ir_lh=0. The IR clears on this edge.
  - Transition: next state IDLE.
- IDLE:
  - Outputs: ir_enable=0, instr_valid=0, PC held.
  - Transition: run=1 -> FETCH_LO.
- FETCH_LO:
  - Outputs: ir_enable=1, ir_funsel=01, ir_lh=0.
  - On the edge: the IR captures mem[PC] into bits [7:0]; PC<=PC+1; next state FETCH_HI. run is ignored here.
- FETCH_HI:
  - Outputs: ir_enable=1, ir_funsel=01, ir_lh=1.
  - On the edge: the IR captures mem[PC] into bits [15:8]; PC<=PC+1; next state VALID.
- Byte order is little-endian: the instruction at address A is {mem[A+1], mem[A]}.
- Latency: instr_valid rises 2 cycles after FETCH_LO is entered.
- VALID:
  - Outputs: instr_valid=1, ir_enable=0. The IR and PC are held indefinitely until instr_ready=1.
  - On handshake (instr_valid & instr_ready):
    - if pc_load=1, PC<=pc_in, else PC unchanged;
    - next state FETCH_LO if run=1, else IDLE.
  - pc_load with instr_ready=0, or in any state other than VALID, is ignored.
- Sustained throughput is one instruction per 3 cycles with instr_ready held high.
- PC arithmetic is modulo 2^ADDR_W: the increment from 2^ADDR_W-1 wraps to 0, no flag.
  - An instruction straddling the wrap reads low byte at 2^ADDR_W-1 and high byte at 0.
- run dropping to 0 during FETCH_LO or FETCH_HI does not abort the fetch; the instruction completes and is handed off, then the block stops in IDLE.
- ir_I = mem_data in all states; it is meaningful only when ir_enable=1 and ir_funsel=01.
- ir_funsel codes 10 and 11 (dec/inc) are never driven.

Test Plan:
- Reset then run=1, mem[0]=0x34, mem[1]=0x12, instr_ready=1:
  - CLR drives funsel=00/enable=1 for one cycle;
  - FETCH_LO presents addr 0, lh=0, I=0x34;
  - FETCH_HI presents addr 1, lh=1, I=0x12;
  - instr_valid=1 on the 3rd cycle after IDLE; pc=2.
- Back-pressure: hold instr_ready=0 for 5 cycles in VALID -> instr_valid stays 1, ir_enable=0, pc stays 2; ready=1 -> FETCH_LO at addr 2 next cycle.
- Jump: in VALID, instr_ready=1, pc_load=1, pc_in=0x40 -> next FETCH_LO addr=0x40.
  - Also: pc_load=1 with instr_ready=0 -> pc unchanged.
- Wrap: ADDR_W=8, PC=0xFF at FETCH_LO -> FETCH_HI addr=0x00, then VALID with pc=0x01.
- Stop: drop run during FETCH_HI -> VALID reached normally; after the handshake state=IDLE, ir_enable=0, pc frozen.
- Async reset asserted mid-FETCH_HI (between clock edges) -> immediately state=CLR, pc=RESET_PC, instr_valid=0; after release one CLR cycle, then IDLE.
